systolic_seq_ctrl: RTL

- Sequences one NxN int8 matrix multiply C = A x B through an NxN array of multiply-accumulate PEs. Each PE registers a and b, then passes them right and down; its clear input loads a*b instead of accumulating.
- Issues k-indexed reads to the A-column and B-row operand buffers, skews each row and column lane by its index, and zero-fills lanes that carry no data.
- Drives a per-PE clear timed to each PE's first operand arrival, and pulses done when every c_out holds its final sum.
- Sits between the operand buffers and the array edge inputs.

---
 rtl/systolic_seq_ctrl_pkg.sv | 23 ++
 rtl/systolic_seq_ctrl_skew_line.sv | 35 +++
 rtl/systolic_seq_ctrl.sv | 91 +++++++++
 3 files changed

// File: rtl/systolic_seq_ctrl_pkg.sv
// Shared state encodings and cycle landmarks for the systolic sequencer.
// Latency: n/a. Backpressure: n/a.
// The cycle landmarks are counted from the start-accept cycle.
package systolic_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FEED  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    function automatic int last_feed(input int n);
        return n - 1;
    endfunction

    function automatic int last_arrival(input int n);
        return 3 * n - 2;
    endfunction

    function automatic int done_cycle(input int n);
        return 3 * n - 1;
    endfunction

endpackage

// File: rtl/systolic_seq_ctrl_skew_line.sv
// Zero-reset delay line used to skew one operand lane into the array edge.
// Latency: DEPTH cycles (DEPTH=0 is a combinational pass).
// Backpressure: none, shifts every cycle.
module skew_line
    import systolic_pkg::*;
#(
    parameter int DEPTH = 1,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    if (DEPTH == 0) begin : g_bypass
        logic bypass_unused;
        assign bypass_unused = ^{clk, rst};
        assign dout = din;
    end else begin : g_pipe
        logic [WIDTH-1:0] pipe [DEPTH];

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int s = 0; s < DEPTH; s++) pipe[s] <= '0;
            end else begin
                pipe[0] <= din;
                for (int s = 1; s < DEPTH; s++) pipe[s] <= pipe[s-1];
            end
        end

        assign dout = pipe[DEPTH-1];
    end

endmodule

// File: rtl/systolic_seq_ctrl.sv
// Sequences one NxN matmul: k-indexed operand reads, per-lane skew, per-PE clear, done.
// Latency: 3N cycles from start accept to done (inclusive).
// Backpressure: none; start is only sampled in IDLE, runs never overlap.
module systolic_seq_ctrl
    import systolic_pkg::*;
#(
    parameter int N     = 4,
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(3*N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 rd_en,
    output logic [$clog2(N)-1:0] rd_k,
    input  logic [N*WIDTH-1:0]   a_col_rdata,
    input  logic [N*WIDTH-1:0]   b_row_rdata,
    output logic [N*WIDTH-1:0]   a_edge,
    output logic [N*WIDTH-1:0]   b_edge,
    output logic [N*N-1:0]       clear_pe
);

    logic [1:0]         state;
    logic [CW-1:0]      cnt;
    logic [CW-1:0]      cnt_nxt;
    logic               rd_vld;
    logic               launch;
    logic [N*WIDTH-1:0] a_masked;
    logic [N*WIDTH-1:0] b_masked;

    // Cycle 0 is the IDLE cycle that sees start, so launch acts combinationally.
    assign launch  = (state == IDLE) && start;
    assign busy    = !rst && (launch || (state != IDLE));
    assign done    = !rst && (state == DONE);
    assign rd_en   = !rst && (launch || (state == FEED));
    assign rd_k    = rd_en ? cnt[$clog2(N)-1:0] : '0;
    assign cnt_nxt = cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            rd_vld <= 1'b0;
        end else begin
            rd_vld <= rd_en;
            if (state == DONE)
                cnt <= '0;
            else if (busy)
                cnt <= cnt_nxt;
            case (state)
                IDLE:    if (start) state <= FEED;
                FEED:    if (cnt == CW'(last_feed(N))) state <= DRAIN;
                DRAIN:   if (cnt == CW'(last_arrival(N))) state <= DONE;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // PE(i,j) sees k=0 in cycle 1+i+j; decode one cycle early and register.
    always_ff @(posedge clk) begin
        if (rst) begin
            clear_pe <= '0;
        end else begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++)
                    clear_pe[i*N+j] <= busy && (cnt_nxt == CW'(i + j + 1));
        end
    end

    assign a_masked = rd_vld ? a_col_rdata : '0;
    assign b_masked = rd_vld ? b_row_rdata : '0;

    for (genvar l = 0; l < N; l++) begin : g_lane
        skew_line #(.DEPTH(l), .WIDTH(WIDTH)) u_a_skew (
            .clk  (clk),
            .rst  (rst),
            .din  (a_masked[l*WIDTH +: WIDTH]),
            .dout (a_edge[l*WIDTH +: WIDTH])
        );
        skew_line #(.DEPTH(l), .WIDTH(WIDTH)) u_b_skew (
            .clk  (clk),
            .rst  (rst),
            .din  (b_masked[l*WIDTH +: WIDTH]),
            .dout (b_edge[l*WIDTH +: WIDTH])
        );
    end

endmodule
